// File: rtl/hv_pwm_intb_sched_pkg.sv
// Shared definitions for the single-wire PWM interrupt link (HV scheduler / LV decoder).
package hv_pwm_intb_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TOGGLE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Burst lengths: toggle count encodes the new interrupt level
  localparam int unsigned INTB_ASSERT_TOGGLES   = 1;
  localparam int unsigned INTB_DEASSERT_TOGGLES = 3;

  // LV detector window: a level must be held strictly between DN and UP cycles
  localparam int unsigned LV_DET_DN = 4;
  localparam int unsigned LV_DET_UP = 8;

  localparam int unsigned TOG_W = 2;

  // Number of toggles needed to signal the given target level (0 = assert)
  function automatic logic [TOG_W-1:0] burst_len(input logic target);
    return target ? TOG_W'(INTB_DEASSERT_TOGGLES) : TOG_W'(INTB_ASSERT_TOGGLES);
  endfunction

endpackage

// File: rtl/hv_pwm_intb_sched.sv
// HV-side scheduler: serialises interrupt level changes into toggle bursts on hv_pwm_intb_n.
module hv_pwm_intb_sched
  import hv_pwm_intb_sched_pkg::*;
#(
  parameter int unsigned SYM_CYC = 6,
  parameter int unsigned GAP_CYC = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_intb_n,
  input  logic i_resync_req,
  output logic o_hv_pwm_intb_n,
  output logic o_sent_intb_n,
  output logic o_busy,
  output logic o_burst_done
);

  localparam int unsigned CNT_W = $clog2(GAP_CYC + 1);

  // Timing parameters must keep each symbol inside the LV window and let LV time out between bursts
  if (SYM_CYC <= LV_DET_DN || SYM_CYC >= LV_DET_UP) begin : g_bad_sym_cyc
    $error("hv_pwm_intb_sched: SYM_CYC must lie strictly between LV_DET_DN and LV_DET_UP");
  end
  if (GAP_CYC < LV_DET_UP + 2) begin : g_bad_gap_cyc
    $error("hv_pwm_intb_sched: GAP_CYC must be at least LV_DET_UP + 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             target_q, target_d;
  logic             line_q, line_d;
  logic             sent_q, sent_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;

  // State and output registers; line idles high out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tog_q    <= '0;
      target_q <= 1'b1;
      line_q   <= 1'b1;
      sent_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tog_q    <= tog_d;
      target_q <= target_d;
      line_q   <= line_d;
      sent_q   <= sent_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  // Next-state logic: launch, symbol timing and inter-burst gap
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    target_d = target_q;
    line_d   = line_q;
    sent_d   = sent_q;
    done_d   = 1'b0;
    pend_d   = pend_q | i_resync_req;

    unique case (state_q)
      ST_IDLE: begin
        // A resync arriving with a level change folds into the same burst
        if ((i_intb_n != sent_q) || pend_q || i_resync_req) begin
          target_d = i_intb_n;
          tog_d    = burst_len(i_intb_n);
          line_d   = ~line_q;
          cnt_d    = '0;
          pend_d   = 1'b0;
          state_d  = ST_TOGGLE;
        end
      end
      ST_TOGGLE: begin
        if (cnt_q == CNT_W'(SYM_CYC - 1)) begin
          cnt_d = '0;
          if (tog_q > TOG_W'(1)) begin
            line_d = ~line_q;
            tog_d  = tog_q - TOG_W'(1);
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          sent_d  = target_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_hv_pwm_intb_n = line_q;
  assign o_sent_intb_n   = sent_q;
  assign o_busy          = busy_q;
  assign o_burst_done    = done_q;

endmodule
